// File: rtl/lvl_state_mover.sv
// lvl_state_mover: moves level-state slots between a flat level-state array
// and a word-wide level-state memory.
// Load:   memory words base..base+n-1 go into array slots 0..n-1.
// Unload: a snapshot of array slots 0..n-1 goes to memory words base..base+n-1.
// Optional feature macro LVL_MOVER_CLR_EN adds one cycle after the last unload
// write. In that cycle the transferred slots are written with zero.
// Slot 0 sits in the MSBs of the array buses and maps to wr_states bit NUM_LVLS-1.

// One array slot. It drives its write enable and its write data. The data
// bus is zero unless a load writeback targets this slot, so clearing a slot
// is just an enable with zero data.
module lvl_slot_lane #(
    parameter int W = 11
) (
    input  logic         ld_sel,
    input  logic         clr_sel,
    input  logic [W-1:0] rdata,
    output logic         we,
    output logic [W-1:0] dout
);
    assign we   = ld_sel | clr_sel;
    assign dout = ld_sel ? rdata : '0;
endmodule

module lvl_state_mover #(
    parameter int NUM_LVLS         = 8,
    parameter int WIDTH_LVL_STATES = 11,
    parameter int WIDTH_ADDR       = 12
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start_load_i,
    input  logic                                 start_unload_i,
    input  logic [WIDTH_ADDR-1:0]                base_addr_i,
    input  logic [3:0]                           num_lvls_i,
    output logic                                 mem_rd_o,
    output logic                                 mem_wr_o,
    output logic [WIDTH_ADDR-1:0]                mem_addr_o,
    output logic [WIDTH_LVL_STATES-1:0]          mem_wdata_o,
    input  logic [WIDTH_LVL_STATES-1:0]          mem_rdata_i,
    output logic [NUM_LVLS-1:0]                  wr_states_o,
    output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_o,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_i,
    output logic                                 busy_o,
    output logic                                 done_o
);
    localparam logic [3:0] NMAX = 4'(NUM_LVLS);

    typedef enum logic [2:0] {IDLE, LOAD, LOAD_WB, UNLOAD, CLEAR, DONE} state_t;

    state_t                                     state_q, state_d;
    logic [3:0]                                 cnt_q, cnt_d;
    logic [3:0]                                 n_q, n_sat;
    logic [WIDTH_ADDR-1:0]                      base_q;
    logic [NUM_LVLS-1:0][WIDTH_LVL_STATES-1:0]  snap_q;
    logic                                       wb_vld_q;
    logic [3:0]                                 wb_idx_q;
    logic                                       accept;

    // Requests above the array size are clamped to a full-array transfer.
    assign n_sat  = (num_lvls_i > NMAX) ? NMAX : num_lvls_i;
    assign accept = (state_q == IDLE) && (start_load_i || start_unload_i);

    // State, index counter and the parameters captured at the accepting edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            base_q  <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                n_q    <= n_sat;
                base_q <= base_addr_i;
                snap_q <= lvl_states_i;
            end
        end
    end

    // Read data returns one cycle after its strobe, so the slot index is
    // delayed by one cycle to line up with the data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_vld_q <= 1'b0;
            wb_idx_q <= '0;
        end else begin
            wb_vld_q <= mem_rd_o;
            wb_idx_q <= cnt_q;
        end
    end

    // Next-state logic. A simultaneous request resolves to the load.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start_load_i)
                    state_d = (n_sat == '0) ? DONE : LOAD;
                else if (start_unload_i)
                    state_d = (n_sat == '0) ? DONE : UNLOAD;
            end
            LOAD: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == n_q - 4'd1) state_d = LOAD_WB;
            end
            LOAD_WB: state_d = DONE;
            UNLOAD: begin
                cnt_d = cnt_q + 4'd1;
`ifdef LVL_MOVER_CLR_EN
                if (cnt_q == n_q - 4'd1) state_d = CLEAR;
`else
                if (cnt_q == n_q - 4'd1) state_d = DONE;
`endif
            end
            CLEAR:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory side: strobes, address and unload data.
    // All of these are zero outside the transfer cycles.
    always_comb begin
        mem_rd_o    = (state_q == LOAD);
        mem_wr_o    = (state_q == UNLOAD);
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (mem_rd_o || mem_wr_o)
            mem_addr_o = base_q + WIDTH_ADDR'(cnt_q);
        for (int i = 0; i < NUM_LVLS; i++)
            if (mem_wr_o && (cnt_q == 4'(i)))
                mem_wdata_o = snap_q[NUM_LVLS-1-i];
    end

    assign busy_o = (state_q == LOAD) || (state_q == LOAD_WB) ||
                    (state_q == UNLOAD) || (state_q == CLEAR);
    assign done_o = (state_q == DONE);

    // Array side: one lane per slot.
    for (genvar i = 0; i < NUM_LVLS; i++) begin : g_lane
        lvl_slot_lane #(.W(WIDTH_LVL_STATES)) u_lane (
            .ld_sel  (wb_vld_q && (wb_idx_q == 4'(i))),
            .clr_sel ((state_q == CLEAR) && (4'(i) < n_q)),
            .rdata   (mem_rdata_i),
            .we      (wr_states_o[NUM_LVLS-1-i]),
            .dout    (lvl_states_o[WIDTH_LVL_STATES*(NUM_LVLS-i)-1 -: WIDTH_LVL_STATES])
        );
    end
endmodule

// File: tb/tb_lvl_state_mover.sv
// Bench for lvl_state_mover.
// A cycle-indexed table of expected outputs is filled from each request's
// base address, count and data, and every cycle is compared against it.
// Literal checks at known cycles pin that table.
module tb_lvl_state_mover;
    logic        clk = 1'b0;
    logic        rst;
    logic        start_load_i, start_unload_i;
    logic [11:0] base_addr_i;
    logic [3:0]  num_lvls_i;
    logic        mem_rd_o, mem_wr_o;
    logic [11:0] mem_addr_o;
    logic [10:0] mem_wdata_o;
    logic [10:0] mem_rdata_i;
    logic [7:0]  wr_states_o;
    logic [87:0] lvl_states_o;
    logic [87:0] lvl_states_i;
    logic        busy_o, done_o;

    lvl_state_mover dut (
        .clk(clk), .rst(rst),
        .start_load_i(start_load_i), .start_unload_i(start_unload_i),
        .base_addr_i(base_addr_i), .num_lvls_i(num_lvls_i),
        .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .wr_states_o(wr_states_o), .lvl_states_o(lvl_states_o),
        .lvl_states_i(lvl_states_i), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr;
        logic [11:0] addr;
        logic [10:0] wdata;
        logic [7:0]  wrs;
        logic [87:0] lvl;
        logic        busy, done;
    } exp_t;

    localparam int NCYC = 1024;
    exp_t        ex [NCYC];
    logic [10:0] mem [4096];
    logic [10:0] slots [8];
    int          cyc = 0;
    int          rd_cnt = 0, wr_cnt = 0;
    int          n_cmp = 0, n_bad = 0;
    logic        cmp_en = 1'b0;

    // Array contents as seen by the DUT, slot 0 in the MSBs.
    always_comb begin
        lvl_states_i = '0;
        for (int i = 0; i < 8; i++) lvl_states_i[11*(8-i)-1 -: 11] = slots[i];
    end

    // Cycle counter, plus a memory that answers one cycle after each read.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        mem_rdata_i <= mem_rd_o ? mem[mem_addr_o] : 11'h0;
        if (mem_rd_o) rd_cnt <= rd_cnt + 1;
        if (mem_wr_o) begin
            mem[mem_addr_o] <= mem_wdata_o;
            wr_cnt <= wr_cnt + 1;
        end
    end

    function automatic int sat(input logic [3:0] n);
        return (n > 4'd8) ? 8 : int'(n);
    endfunction

    task automatic clr_exp(input int from, input int to);
        for (int c = from; c <= to && c < NCYC; c++) begin
            ex[c].rd = 0; ex[c].wr = 0; ex[c].addr = 0; ex[c].wdata = 0;
            ex[c].wrs = 0; ex[c].lvl = 0; ex[c].busy = 0; ex[c].done = 0;
        end
    endtask

    task automatic sched_load(input int t, input logic [11:0] base, input logic [3:0] nin);
        int n = sat(nin);
        if (n == 0) begin ex[t+1].done = 1; return; end
        for (int k = 0; k < n; k++) begin
            ex[t+1+k].rd   = 1;
            ex[t+1+k].addr = 12'(base + k);
            ex[t+2+k].wrs[7-k] = 1'b1;
            ex[t+2+k].lvl[11*(8-k)-1 -: 11] = mem[12'(base + k)];
        end
        for (int c = t + 1; c <= t + n + 1; c++) ex[c].busy = 1;
        ex[t+n+2].done = 1;
    endtask

    task automatic sched_unload(input int t, input logic [11:0] base, input logic [3:0] nin);
        int n = sat(nin);
        if (n == 0) begin ex[t+1].done = 1; return; end
        for (int k = 0; k < n; k++) begin
            ex[t+1+k].wr    = 1;
            ex[t+1+k].addr  = 12'(base + k);
            ex[t+1+k].wdata = slots[k];
            ex[t+1+k].busy  = 1;
        end
`ifdef LVL_MOVER_CLR_EN
        for (int k = 0; k < n; k++) ex[t+n+1].wrs[7-k] = 1'b1;
        ex[t+n+1].busy = 1;
        ex[t+n+2].done = 1;
`else
        ex[t+n+1].done = 1;
`endif
    endtask

    // Every cycle: compare all outputs with the expected table.
    // The address is checked only on cycles that have a strobe.
    always @(negedge clk) begin
        if (cmp_en && cyc < NCYC) begin
            exp_t e;
            logic ok;
            e  = ex[cyc];
            ok = (mem_rd_o === e.rd) && (mem_wr_o === e.wr) &&
                 (mem_wdata_o === e.wdata) && (wr_states_o === e.wrs) &&
                 (lvl_states_o === e.lvl) && (busy_o === e.busy) &&
                 (done_o === e.done) &&
                 (!(e.rd || e.wr) || (mem_addr_o === e.addr));
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL cycle%0d: got rd=%b wr=%b addr=%h wd=%h wrs=%h lvl=%h busy=%b done=%b ; want rd=%b wr=%b addr=%h wd=%h wrs=%h lvl=%h busy=%b done=%b",
                         cyc, mem_rd_o, mem_wr_o, mem_addr_o, mem_wdata_o, wr_states_o, lvl_states_o, busy_o, done_o,
                         e.rd, e.wr, e.addr, e.wdata, e.wrs, e.lvl, e.busy, e.done);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Called at a negedge. The request is held for exactly one cycle (cycle t),
    // and the task returns at the negedge of cycle t+1.
    task automatic do_op(input logic ld, input logic ul, input logic [11:0] base,
                         input logic [3:0] n, output int t);
        start_load_i = ld; start_unload_i = ul; base_addr_i = base; num_lvls_i = n;
        t = cyc;
        if (ld) sched_load(t, base, n);
        else if (ul) sched_unload(t, base, n);
        @(negedge clk);
        start_load_i = 0; start_unload_i = 0;
        base_addr_i = 12'hABC; num_lvls_i = 4'd7;
    endtask

    initial begin
        int t, r0, w0;
        rst = 1; start_load_i = 0; start_unload_i = 0; base_addr_i = 0; num_lvls_i = 0;
        for (int a = 0; a < 4096; a++) mem[a] = 11'((a * 7 + 3) & 11'h7FF);
        mem[12'h010] = 11'h155; mem[12'h011] = 11'h2AA; mem[12'h012] = 11'h001;
        for (int i = 0; i < 8; i++) slots[i] = 11'h0;
        clr_exp(0, NCYC - 1);
        cmp_en = 1;
        @(negedge clk);
        chk("reset_busy_done", {30'd0, busy_o, done_o}, 32'd0);
        chk("reset_wrs", {24'd0, wr_states_o}, 32'd0);
        @(negedge clk); rst = 0;
        repeat (2) @(negedge clk);

        // Load example: base 0x010, three slots.
        do_op(1, 0, 12'h010, 4'd3, t);
        chk("ld_rd_t1", {19'd0, mem_rd_o, mem_addr_o}, {19'd0, 1'b1, 12'h010});
        wait_to(t + 2);
        chk("ld_wrs_t2", {24'd0, wr_states_o}, 32'h80);
        chk("ld_slot0", {21'd0, lvl_states_o[87:77]}, 32'h155);
        wait_to(t + 3); chk("ld_wrs_t3", {24'd0, wr_states_o}, 32'h40);
        wait_to(t + 4); chk("ld_wrs_t4", {24'd0, wr_states_o}, 32'h20);
        chk("ld_slot2", {21'd0, lvl_states_o[65:55]}, 32'h001);
        wait_to(t + 5); chk("ld_done_t5", {31'd0, done_o}, 32'd1);
        repeat (3) @(negedge clk);

        // Full unload. The array changes after acceptance, and the writes
        // must still carry the values present at acceptance.
        for (int i = 0; i < 8; i++) slots[i] = 11'(i * 3);
        do_op(0, 1, 12'h100, 4'd8, t);
        for (int i = 0; i < 8; i++) slots[i] = 11'h7FF;
        wait_to(t + 8);
        chk("ul_wd_last", {9'd0, mem_addr_o, mem_wdata_o}, {9'd0, 12'h107, 11'd21});
`ifdef LVL_MOVER_CLR_EN
        wait_to(t + 9);  chk("ul_clr_mask", {24'd0, wr_states_o}, 32'hFF);
        wait_to(t + 10); chk("ul_done_t10", {31'd0, done_o}, 32'd1);
`else
        wait_to(t + 9);  chk("ul_done_t9", {31'd0, done_o}, 32'd1);
`endif
        repeat (3) @(negedge clk);
        chk("ul_mem3", {21'd0, mem[12'h103]}, 32'd9);

        // Simultaneous requests: only the load runs.
        r0 = rd_cnt; w0 = wr_cnt;
        do_op(1, 1, 12'h200, 4'd2, t);
        repeat (6) @(negedge clk);
        chk("both_rd_cnt", 32'(rd_cnt - r0), 32'd2);
        chk("both_wr_cnt", 32'(wr_cnt - w0), 32'd0);

        // Address wrap on a load.
        do_op(1, 0, 12'hFFE, 4'd4, t);
        wait_to(t + 3); chk("wrap_addr_t3", {20'd0, mem_addr_o}, 32'h000);
        wait_to(t + 4); chk("wrap_addr_t4", {20'd0, mem_addr_o}, 32'h001);
        repeat (4) @(negedge clk);

        // Address wrap on an unload of three slots.
        for (int i = 0; i < 8; i++) slots[i] = 11'(11'h400 + i);
        do_op(0, 1, 12'hFFF, 4'd3, t);
        repeat (6) @(negedge clk);
        chk("ul_wrap_mem1", {21'd0, mem[12'h001]}, 32'h402);

        // Zero-count requests finish at once with no strobes.
        r0 = rd_cnt;
        do_op(1, 0, 12'h050, 4'd0, t);
        chk("n0_done_t1", {30'd0, done_o, busy_o}, 32'd2);
        repeat (2) @(negedge clk);
        do_op(0, 1, 12'h050, 4'd0, t);
        repeat (2) @(negedge clk);
        chk("n0_no_rd", 32'(rd_cnt - r0), 32'd0);

        // Count above the array size is clamped to a full-array transfer.
        r0 = rd_cnt;
        do_op(1, 0, 12'h060, 4'd12, t);
        repeat (12) @(negedge clk);
        chk("n12_rd_cnt", 32'(rd_cnt - r0), 32'd8);

        // A request raised while busy is ignored.
        w0 = wr_cnt;
        do_op(1, 0, 12'h020, 4'd4, t);
        start_unload_i = 1; start_load_i = 1; num_lvls_i = 4'd5;
        repeat (2) @(negedge clk);
        start_unload_i = 0; start_load_i = 0;
        repeat (8) @(negedge clk);
        chk("busy_ignored_wr", 32'(wr_cnt - w0), 32'd0);

        // Reset asserted during cycle t+2 of a full load.
        do_op(1, 0, 12'h300, 4'd8, t);
        clr_exp(t + 2, t + 20);
        @(posedge clk); #2 rst = 1;
        #1;
        chk("rst_async_rd", {31'd0, mem_rd_o}, 32'd0);
        chk("rst_async_wrs", {24'd0, wr_states_o}, 32'd0);
        chk("rst_async_lvl", 32'(lvl_states_o[87:56] | lvl_states_o[55:24] | 32'(lvl_states_o[23:0])), 32'd0);
        chk("rst_async_busy", {31'd0, busy_o}, 32'd0);
        @(negedge clk); @(negedge clk); rst = 0;
        repeat (10) @(negedge clk);

        // A request after the aborted transfer runs normally.
        do_op(1, 0, 12'h010, 4'd2, t);
        wait_to(t + 2); chk("post_rst_wrs", {24'd0, wr_states_o}, 32'h80);
        wait_to(t + 4); chk("post_rst_done", {31'd0, done_o}, 32'd1);
        repeat (3) @(negedge clk);

        cmp_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lvl_state_mover.md
LVL_STATE_MOVER -- requirements
Module: lvl_state_mover

Interface
REQ-001 Parameter NUM_LVLS, default 8: number of level slots held by the level-state array.
REQ-002 Parameter WIDTH_LVL_STATES, default 11: bits per slot, {dcd_bin[9:0], has_bkt}.
REQ-003 Parameter WIDTH_ADDR, default 12: level-state memory address width.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port start_load_i, input, 1: request to copy memory into the array.
REQ-007 Port start_unload_i, input, 1: request to copy the array into memory.
REQ-008 Port base_addr_i, input, WIDTH_ADDR: memory address of slot 0, sampled at start.
REQ-009 Port num_lvls_i, input, 4: slots to transfer (0..NUM_LVLS), sampled at start.
REQ-010 Port mem_rd_o / mem_wr_o, output, 1 each: memory read / write strobes.
REQ-011 Port mem_addr_o, output, WIDTH_ADDR: memory address.
REQ-012 Port mem_wdata_o, output, WIDTH_LVL_STATES: write data.
REQ-013 Port mem_rdata_i, input, WIDTH_LVL_STATES: read data, valid exactly one cycle after mem_rd_o.
REQ-014 Port wr_states_o, output, NUM_LVLS: one-hot slot write enable to the array.
REQ-015 Port lvl_states_o, output, WIDTH_LVL_STATES*NUM_LVLS: write data to the array.
REQ-016 Port lvl_states_i, input, WIDTH_LVL_STATES*NUM_LVLS: current array contents.
REQ-017 Port busy_o / done_o, output, 1 each: transfer in progress / one-cycle completion pulse.

Function
REQ-018 Slot i SHALL occupy lvl_states bits [WIDTH_LVL_STATES*(NUM_LVLS-i)-1 -: WIDTH_LVL_STATES] (slot 0 in MSBs), and wr_states bit NUM_LVLS-1-i.
REQ-019 FSM states SHALL be IDLE, LOAD, LOAD_WB, UNLOAD, CLEAR, DONE.
REQ-020 Start requests SHALL be sampled only in IDLE; starts while busy_o=1 SHALL be ignored.
REQ-021 Simultaneous start_load_i and start_unload_i SHALL execute the load only.
REQ-022 Load accepted at cycle T: cycles T+1..T+n assert mem_rd_o with mem_addr_o=base+k (k=0..n-1); cycles T+2..T+n+1 assert the one-hot wr_states_o for slot k with mem_rdata_i placed in slot k of lvl_states_o.
REQ-023 Unload accepted at cycle T SHALL snapshot lvl_states_i at T; cycles T+1..T+n assert mem_wr_o, mem_addr_o=base+k, mem_wdata_o=snapshot slot k.
REQ-024 done_o SHALL pulse the cycle after the last transfer (or CLEAR) cycle; busy_o high from T+1 through that last cycle; return to IDLE with done_o.
REQ-025 num_lvls_i=0 SHALL give done_o at T+1 with no strobes; values above NUM_LVLS SHALL saturate to NUM_LVLS.
REQ-026 Addresses SHALL wrap modulo 2^WIDTH_ADDR.
REQ-027 Outside active cycles, strobes, wr_states_o, mem_wdata_o and lvl_states_o SHALL be zero.

Reset
REQ-028 rst SHALL force IDLE and zero every output immediately, aborting any transfer mid-operation with no done_o pulse.

Configuration
REQ-029 With LVL_MOVER_CLR_EN defined, unload SHALL add one CLEAR cycle after the last write asserting wr_states_o for all transferred slots with lvl_states_o=0; without it, unload goes directly to DONE.

Verification
REQ-030 Load base=0x010, n=3, memory {0x155,0x2AA,0x001} -> reads 0x010..0x012 at T+1..T+3, wr_states_o 0x80,0x40,0x20 at T+2..T+4, done_o at T+5.
REQ-031 Unload n=8 from array of slot value i*3 -> eight writes, data 0,3,..,21, done_o at T+9 (T+10 with LVL_MOVER_CLR_EN, clear mask 0xFF).
REQ-032 Both starts at once, n=2 -> only mem_rd_o activity, no mem_wr_o.
REQ-033 base=0xFFE, n=4 -> addresses 0xFFE,0xFFF,0x000,0x001.
REQ-034 n=0 -> done_o at T+1, no strobes; n=12 -> exactly 8 transfers.
REQ-035 rst asserted at T+2 of an n=8 load -> all outputs zero asynchronously, no done_o, next start accepted normally.
